// File: rtl/encrypt_v3.sv
// encrypt_v3: iterative PRESENT-80/128 block cipher, round-reduced, encrypt and decrypt
module encrypt_v3 #(
    parameter int N_K    = 80,
    parameter int ROUNDS = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           dec,
    input  logic [N_K-1:0] k,
    input  logic [63:0]    m,
    output logic [63:0]    c,
    output logic           ack
);
    if (N_K != 80 && N_K != 128) begin : g_bad_nk
        $error("encrypt_v3: N_K must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("encrypt_v3: ROUNDS must be in 1..31");
    end

    localparam logic [4:0]  R   = 5'(ROUNDS);
    localparam int          CB  = (N_K == 128) ? 66 : 19;
    localparam logic [63:0] SB  = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBI = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_t;

    function automatic logic [3:0] sub(input logic [63:0] tbl, input logic [3:0] x);
        return tbl[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] layer(input logic [63:0] x, input logic [63:0] tbl);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = sub(tbl, x[4*i +: 4]);
        return o;
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] x);
        logic [63:0] o;
        o[63] = x[63];
        for (int i = 0; i < 63; i++) o[(i*16) % 63] = x[i];
        return o;
    endfunction

    function automatic logic [63:0] iperm(input logic [63:0] x);
        logic [63:0] o;
        o[63] = x[63];
        for (int i = 0; i < 63; i++) o[i] = x[(i*16) % 63];
        return o;
    endfunction

    function automatic logic [N_K-1:0] kfwd(input logic [N_K-1:0] x, input logic [4:0] r);
        logic [N_K-1:0] t;
        t = (x << 61) | (x >> (N_K - 61));
        t[N_K-1 -: 4] = sub(SB, t[N_K-1 -: 4]);
        if (N_K == 128) t[N_K-5 -: 4] = sub(SB, t[N_K-5 -: 4]);
        t[CB -: 5] = t[CB -: 5] ^ r;
        return t;
    endfunction

    function automatic logic [N_K-1:0] kinv(input logic [N_K-1:0] x, input logic [4:0] r);
        logic [N_K-1:0] t;
        t = x;
        t[CB -: 5] = t[CB -: 5] ^ r;
        t[N_K-1 -: 4] = sub(SBI, t[N_K-1 -: 4]);
        if (N_K == 128) t[N_K-5 -: 4] = sub(SBI, t[N_K-5 -: 4]);
        return (t >> 61) | (t << (N_K - 61));
    endfunction

    fsm_t           fsm_q, fsm_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [63:0]    st_q, st_d;
    logic [N_K-1:0] key_q, key_d;
    logic           dec_q, dec_d;
    logic [N_K-1:0] kf, ki;
    logic [63:0]    enc_r, dec_r;
    logic           last;

    // Decrypt peels rounds in reverse: state ^ K_j undoes the layers, the key steps back to K_(j-1).
    assign kf    = kfwd(key_q, cnt_q);
    assign ki    = kinv(key_q, cnt_q);
    assign enc_r = perm(layer(st_q ^ key_q[N_K-1 -: 64], SB));
    assign dec_r = layer(iperm(st_q ^ key_q[N_K-1 -: 64]), SBI);
    assign last  = cnt_q == (dec_q ? 5'd1 : R);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    // Next state: dropping req anywhere before DONE abandons the operation
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    fsm_d = req ? (dec ? KEYEXP : ROUND) : IDLE;
            KEYEXP:  fsm_d = !req ? IDLE : (cnt_q == R) ? ROUND : KEYEXP;
            ROUND:   fsm_d = !req ? IDLE : last ? DONE : ROUND;
            default: fsm_d = req ? DONE : IDLE;
        endcase
    end

    // Datapath next state: last round folds in the whitening key so DONE holds the result
    always_comb begin
        st_d  = st_q;
        key_d = key_q;
        cnt_d = cnt_q;
        dec_d = dec_q;
        case (fsm_q)
            IDLE: if (req) begin
                st_d  = m;
                key_d = k;
                dec_d = dec;
                cnt_d = 5'd1;
            end
            KEYEXP: begin
                key_d = kf;
                cnt_d = (cnt_q == R) ? cnt_q : cnt_q + 5'd1;
            end
            ROUND: begin
                key_d = dec_q ? ki : kf;
                cnt_d = dec_q ? cnt_q - 5'd1 : cnt_q + 5'd1;
                st_d  = dec_q ? (last ? dec_r ^ ki[N_K-1 -: 64] : dec_r)
                              : (last ? enc_r ^ kf[N_K-1 -: 64] : enc_r);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= '0;
            key_q <= '0;
            cnt_q <= '0;
            dec_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            key_q <= key_d;
            cnt_q <= cnt_d;
            dec_q <= dec_d;
        end
    end

    // Outputs: result exposed only in DONE, zero otherwise
    always_comb begin
        ack = fsm_q == DONE;
        c   = ack ? st_q : '0;
    end
endmodule

// File: tb/tb_encrypt_v3.sv
// tb_encrypt_v3: PRESENT-80/128 reference model checking four encrypt_v3 configurations
module tb_encrypt_v3;
    logic         clk = 1'b0;
    logic         rst;
    logic         req [4];
    logic         dec [4];
    logic [127:0] kk  [4];
    logic [63:0]  mm  [4];
    logic [63:0]  cc  [4];
    logic         ack [4];
    logic [63:0]  expc[4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NKG = (g == 0) ? 80 : 128;
        localparam int RG  = (g == 2) ? 1 : (g == 3) ? 7 : 31;
        encrypt_v3 #(.N_K(NKG), .ROUNDS(RG)) u_dut (
            .clk(clk), .rst(rst), .req(req[g]), .dec(dec[g]),
            .k(kk[g][NKG-1:0]), .m(mm[g]), .c(cc[g]), .ack(ack[g])
        );
    end

    function automatic int nkg(int g); return (g == 0) ? 80 : 128; endfunction
    function automatic int rg(int g);  return (g == 2) ? 1 : (g == 3) ? 7 : 31; endfunction

    localparam logic [3:0] SBT[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic logic [3:0] isb(logic [3:0] v);
        for (int i = 0; i < 16; i++) if (SBT[i] == v) return 4'(i);
        return 4'h0;
    endfunction

    function automatic logic [63:0] subl(logic [63:0] s, bit inv);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) o[4*n +: 4] = inv ? isb(s[4*n +: 4]) : SBT[s[4*n +: 4]];
        return o;
    endfunction

    function automatic int pdst(int i); return (i == 63) ? 63 : (i * 16) % 63; endfunction

    function automatic logic [63:0] pm(logic [63:0] s, bit inv);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) if (inv) o[i] = s[pdst(i)]; else o[pdst(i)] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] ks(logic [127:0] key, int nk, int r);
        logic [127:0] t = '0;
        for (int i = 0; i < nk; i++) t[(i + 61) % nk] = key[i];
        t[nk-1 -: 4] = SBT[t[nk-1 -: 4]];
        if (nk == 128) t[nk-5 -: 4] = SBT[t[nk-5 -: 4]];
        for (int b = 0; b < 5; b++) t[((nk == 80) ? 15 : 62) + b] ^= r[b];
        return t;
    endfunction

    function automatic logic [63:0] menc(int nk, int rn, logic [127:0] key, logic [63:0] msg);
        logic [63:0]  s  = msg;
        logic [127:0] kr = key;
        for (int i = 1; i <= rn; i++) begin
            s  = pm(subl(s ^ kr[nk-1 -: 64], 1'b0), 1'b0);
            kr = ks(kr, nk, i);
        end
        return s ^ kr[nk-1 -: 64];
    endfunction

    function automatic logic [63:0] mdec(int nk, int rn, logic [127:0] key, logic [63:0] ct);
        logic [63:0]  rk[32];
        logic [63:0]  s;
        logic [127:0] kr = key;
        for (int i = 0; i <= rn; i++) begin
            rk[i] = kr[nk-1 -: 64];
            if (i < rn) kr = ks(kr, nk, i + 1);
        end
        s = ct ^ rk[rn];
        for (int i = rn; i >= 1; i--) s = subl(pm(s, 1'b1), 1'b1) ^ rk[i-1];
        return s;
    endfunction

    function automatic logic [127:0] rkey(int g);
        logic [127:0] v = {$urandom, $urandom, $urandom, $urandom};
        return (g == 0) ? {48'h0, v[79:0]} : v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: result computed at the load edge, ack after a fixed latency
    logic        mbusy[4], mdone[4];
    int          mrem [4];
    logic [63:0] mres [4];

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 4; g++) begin
            if (rst) begin
                mbusy[g] <= 1'b0;
                mdone[g] <= 1'b0;
            end else if (mdone[g]) begin
                if (!req[g]) mdone[g] <= 1'b0;
            end else if (mbusy[g]) begin
                if (!req[g]) mbusy[g] <= 1'b0;
                else if (mrem[g] == 1) begin
                    mbusy[g] <= 1'b0;
                    mdone[g] <= 1'b1;
                end else mrem[g] <= mrem[g] - 1;
            end else if (req[g]) begin
                mbusy[g] <= 1'b1;
                mrem[g]  <= dec[g] ? 2 * rg(g) : rg(g);
                mres[g]  <= dec[g] ? mdec(nkg(g), rg(g), kk[g], mm[g])
                                   : menc(nkg(g), rg(g), kk[g], mm[g]);
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("cyc_ack%0d", g), {63'h0, ack[g]}, {63'h0, mdone[g]});
            chk($sformatf("cyc_c%0d", g), cc[g], mdone[g] ? mres[g] : 64'h0);
        end
    end

    task automatic go(input logic [3:0] d, input logic [3:0] en, input int hold,
                      input bit tog, input bit rdone);
        bit got[4];
        int n = 0;
        for (int g = 0; g < 4; g++) begin
            got[g] = !en[g];
            req[g] = en[g];
            dec[g] = d[g];
        end
        while (n < 200 && !(got[0] && got[1] && got[2] && got[3])) begin
            @(negedge clk);
            n++;
            for (int g = 0; g < 4; g++) if (!got[g] && ack[g]) begin
                got[g] = 1'b1;
                chk($sformatf("latency%0d", g), 64'(n), 64'(d[g] ? 2 * rg(g) + 1 : rg(g) + 1));
                chk($sformatf("result%0d", g), cc[g], expc[g]);
            end
            if (tog) for (int g = 0; g < 4; g++) if (en[g]) begin
                kk[g]  = rkey(g);
                mm[g]  = {$urandom, $urandom};
                dec[g] = 1'($urandom);
            end
        end
        for (int g = 0; g < 4; g++) if (!got[g]) chk($sformatf("timeout%0d", g), 64'(n), 64'hFFFF);
        if (rdone) begin
            #2 rst = 1'b1;
            #1 for (int g = 0; g < 4; g++) if (en[g]) begin
                chk($sformatf("rst_ack%0d", g), {63'h0, ack[g]}, 64'h0);
                chk($sformatf("rst_c%0d", g), cc[g], 64'h0);
                req[g] = 1'b0;
            end
            #1 rst = 1'b0;
            @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
            for (int g = 0; g < 4; g++) req[g] = 1'b0;
            @(negedge clk);
            for (int g = 0; g < 4; g++) if (en[g]) begin
                chk($sformatf("drop_ack%0d", g), {63'h0, ack[g]}, 64'h0);
                chk($sformatf("drop_c%0d", g), cc[g], 64'h0);
            end
        end
    endtask

    initial begin
        logic [127:0] key_s[4];
        logic [63:0]  pt[4], ct[4];
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            req[g] = 1'b0; dec[g] = 1'b0; kk[g] = '0; mm[g] = '0; expc[g] = '0;
        end
        #1 for (int g = 0; g < 4; g++) begin
            chk($sformatf("reset_ack%0d", g), {63'h0, ack[g]}, 64'h0);
            chk($sformatf("reset_c%0d", g), cc[g], 64'h0);
        end
        chk("model_enc0", menc(80, 31, '0, '0), 64'h5579C1387B228445);
        chk("model_enc1", menc(80, 31, {48'h0, {80{1'b1}}}, '1), 64'h3333DCD3213210D2);
        chk("model_dec0", mdec(80, 31, '0, 64'h5579C1387B228445), 64'h0);
        chk("model_dec1", mdec(80, 31, {48'h0, {80{1'b1}}}, 64'hE72C46C0F5945049), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        kk[0] = '0; mm[0] = '0; expc[0] = 64'h5579C1387B228445;
        go(4'b0000, 4'b0001, 10, 1'b0, 1'b0);
        kk[0] = {48'h0, {80{1'b1}}}; mm[0] = '1; expc[0] = 64'h3333DCD3213210D2;
        go(4'b0000, 4'b0001, 2, 1'b1, 1'b0);
        kk[0] = '0; mm[0] = 64'h5579C1387B228445; expc[0] = 64'h0;
        go(4'b0001, 4'b0001, 3, 1'b0, 1'b0);
        kk[0] = {48'h0, {80{1'b1}}}; mm[0] = 64'hE72C46C0F5945049; expc[0] = 64'h0;
        go(4'b0001, 4'b0001, 1, 1'b1, 1'b0);

        for (int d = 0; d < 2; d++) begin
            kk[0] = rkey(0); mm[0] = {$urandom, $urandom};
            dec[0] = 1'(d); req[0] = 1'b1;
            repeat (15) @(negedge clk);
            req[0] = 1'b0;
            repeat (6) begin
                @(negedge clk);
                chk("abort_ack", {63'h0, ack[0]}, 64'h0);
            end
            expc[0] = menc(80, 31, kk[0], mm[0]);
            go(4'b0000, 4'b0001, 0, 1'b0, 1'b0);
        end

        kk[0] = rkey(0); mm[0] = {$urandom, $urandom}; dec[0] = 1'b0; req[0] = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midrst_ack", {63'h0, ack[0]}, 64'h0);
        chk("midrst_c", cc[0], 64'h0);
        req[0] = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        expc[0] = menc(80, 31, kk[0], mm[0]);
        go(4'b0000, 4'b0001, 0, 1'b0, 1'b0);
        expc[0] = menc(80, 31, kk[0], mm[0]);
        go(4'b0000, 4'b0001, 0, 1'b0, 1'b1);
        expc[0] = menc(80, 31, kk[0], mm[0]);
        go(4'b0000, 4'b0001, 1, 1'b0, 1'b0);

        repeat (40) begin
            for (int g = 0; g < 4; g++) begin
                key_s[g] = rkey(g);
                pt[g]    = {$urandom, $urandom};
                ct[g]    = menc(nkg(g), rg(g), key_s[g], pt[g]);
                chk($sformatf("model_rt%0d", g), mdec(nkg(g), rg(g), key_s[g], ct[g]), pt[g]);
                kk[g] = key_s[g]; mm[g] = pt[g]; expc[g] = ct[g];
            end
            go(4'b0000, 4'b1111, $urandom_range(0, 2), 1'($urandom), 1'b0);
            for (int g = 0; g < 4; g++) begin
                kk[g] = key_s[g]; mm[g] = ct[g]; expc[g] = pt[g];
            end
            go(4'b1111, 4'b1111, $urandom_range(0, 2), 1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encrypt_v3.md
ENCRYPT_V3 -- requirements
Module: encrypt_v3

Interface
REQ-001 Parameter N_K, default 80, key width in bits; legal values 80 and 128 only, any other value a synthesis/elaboration error.
REQ-002 Parameter ROUNDS, default 31, number of full PRESENT rounds; legal range 1..31.
REQ-003 Block width fixed at 64 bits.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  1  level request; four-phase handshake with ack.
REQ-007 dec  input  1  mode: 0 = encrypt, 1 = decrypt; sampled with req.
REQ-008 k  input  N_K  cipher key.
REQ-009 m  input  64  input block: plaintext (dec=0) or ciphertext (dec=1).
REQ-010 c  output  64  result block, valid only while ack=1.
REQ-011 ack  output  1  result valid / operation complete.

Function
REQ-012 Encryption SHALL equal PRESENT-N_K truncated to ROUNDS rounds: per round i = 1..ROUNDS: state ^= K_i (top 64 bits of key register), S-box layer, P-layer, key register updated with round counter i; output = state ^ K_(ROUNDS+1).
REQ-013 Key schedule SHALL follow PRESENT-80 (rotate left 61, S-box on top nibble, XOR counter into bits 19:15) or PRESENT-128 (rotate left 61, S-box on top two nibbles, XOR counter into bits 66:62) per N_K.
REQ-014 Decryption SHALL be the exact inverse of REQ-012 for the same k and ROUNDS: decrypt(encrypt(x)) = x for every x, k.
REQ-015 FSM states: IDLE, KEYEXP, ROUND, DONE; 5-bit round counter; 64-bit state register; N_K-bit key register.
REQ-016 IDLE: on a rising edge with req=1, latch m, k, dec, set counter=1; next state ROUND if dec=0, KEYEXP if dec=1 (the "load edge").
REQ-017 KEYEXP: one forward key-schedule step per cycle for ROUNDS cycles, leaving K_(ROUNDS+1) in the key register, counter left at ROUNDS; then ROUND.
REQ-018 ROUND, encrypt: one round per cycle for ROUNDS cycles, counter incrementing; decrypt: first cycle applies state ^= K_(ROUNDS+1), then each cycle applies inverse P-layer, inverse S-box, ^K_i and one inverse key-schedule step, counter decrementing from ROUNDS to 1.
REQ-019 On leaving ROUND, c SHALL be registered with the final result and ack set to 1; next state DONE.
REQ-020 Latency from load edge to first cycle with ack=1: ROUNDS+1 edges (encrypt, 32 default); 2*ROUNDS+1 edges (decrypt, 63 default).
REQ-021 DONE: ack=1 and c stable for as long as req=1; on the first edge with req=0, ack->0, c->0, next state IDLE.
REQ-022 A new operation SHALL start only from IDLE; req must be observed low for at least one edge between operations.
REQ-023 req falling in KEYEXP or ROUND SHALL abort: next edge enters IDLE, ack stays 0, c stays 0, no partial result exposed.
REQ-024 Changes on k, m, dec after the load edge SHALL have no effect on the running operation.
REQ-025 c SHALL read 0 whenever ack=0.

Reset
REQ-026 rst=1 SHALL immediately (no clock needed) force state IDLE, ack=0, c=0, counter=0; state and key registers cleared.
REQ-027 rst asserted mid-operation SHALL discard the operation; after rst falls, the block is idle and accepts a request on the next edge with req=1.
REQ-028 rst has priority over req on the same edge.

Verification
REQ-029 N_K=80, ROUNDS=31, dec=0, k=0, m=0 -> ack after 32 edges, c=5579C1387B228445; k=all-ones, m=all-ones -> c=3333DCD3213210D2.
REQ-030 N_K=80, dec=1, k=0, m=5579C1387B228445 -> ack after 63 edges, c=0000000000000000; k=all-ones, m=E72C46C0F5945049 -> c=0.
REQ-031 N_K=128 and ROUNDS in {1, 7, 31}: 1000 random (k, m) encrypt then decrypt -> recovered block equals m; encrypt output matches software model.
REQ-032 Handshake: req held high 10 cycles past ack -> c and ack constant; req low one edge -> ack=0, c=0, state IDLE; req high immediately after -> new operation with new inputs.
REQ-033 Abort/reset: req dropped at round 15 -> ack never rises, block idle next edge; rst pulsed between edges at round 10 -> ack=0, c=0 immediately; subsequent request returns correct result.
REQ-034 Input isolation: toggle k, m, dec every cycle after load edge -> result equals that of the latched inputs.
